// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared constants and types for the clocked ARM register file.
//   DEF_DATA_W / DEF_ADDR_W / DEF_NUM_RD / DEF_PC_IDX : default geometry
//   RESET_VAL  : value every entry and every registered output takes on reset
//   pc_idx_t   : index type for the program-counter entry (default geometry)
// Optional feature macro used by the design: REGFILE_BYPASS_EN
// -----------------------------------------------------------------------------
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_NUM_RD = 3;
  localparam int DEF_PC_IDX = 15;

  // Wide enough for any practical DATA_W; users size-cast it down.
  localparam logic [63:0] RESET_VAL = 64'h0000_0000_0000_0000;

  typedef logic [DEF_ADDR_W-1:0] pc_idx_t;

endpackage

// File: rtl/regfile_rd_port.sv
// -----------------------------------------------------------------------------
// regfile_rd_port
// One registered read port of the register file.
//   clk, rst          : clock, synchronous active-high reset
//   en, addr          : read enable and entry address
//   entries           : current contents of the storage array
//   wa_en/addr/data   : data write landing this cycle (already arbitrated)
//   wb_en/addr/data   : PC write landing this cycle
//   data, valid       : registered read data (held when idle), one-cycle valid
// With REGFILE_BYPASS_EN defined, a read that hits an address being written
// in the same cycle returns the new value; otherwise it returns the old one.
// -----------------------------------------------------------------------------
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] entries [2**ADDR_W],
  input  logic              wa_en,
  input  logic [ADDR_W-1:0] wa_addr,
  input  logic [DATA_W-1:0] wa_data,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] data,
  output logic              valid
);

  logic [DATA_W-1:0] sel_data_s;
  logic [DATA_W-1:0] data_r;
  logic              valid_r;

`ifdef REGFILE_BYPASS_EN
  // Select the value to capture, forwarding a same-cycle write when it hits.
  always_comb begin
    sel_data_s = entries[addr];
    if (wb_en && (wb_addr == addr)) begin
      sel_data_s = wb_data;
    end else if (wa_en && (wa_addr == addr)) begin
      sel_data_s = wa_data;
    end else begin
      sel_data_s = entries[addr];
    end
  end
`else
  logic unused_byp_s;
  assign unused_byp_s = ^{wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data};

  // Select the value to capture: stored (pre-write) contents only.
  always_comb begin
    sel_data_s = entries[addr];
  end
`endif

  // Output register: capture on enable, hold data otherwise, pulse valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_r  <= DATA_W'(RESET_VAL);
      valid_r <= 1'b0;
    end else if (en) begin
      data_r  <= sel_data_s;
      valid_r <= 1'b1;
    end else begin
      valid_r <= 1'b0;
    end
  end

  assign data  = data_r;
  assign valid = valid_r;

endmodule

// File: rtl/regfile_param.sv
// -----------------------------------------------------------------------------
// regfile_param
// Clocked, parametrised general-purpose register file with a dedicated
// program-counter path.
//   clk, rst     : clock, synchronous active-high reset (clears all entries)
//   rd_en        : per-port read enable                       [NUM_RD]
//   rd_addr      : packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rd_data      : packed registered read data, port i at [i*DATA_W +: DATA_W]
//   rd_valid     : per-port one-cycle pulse when rd_data was updated
//   wr_en/addr/data : writeback data write
//   pc_rd_en, pc_rd_data : registered read of entry PC_IDX
//   pc_wr_en, pc_wr_data : write of entry PC_IDX (wins over a colliding wr_en)
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle write-to-read forward).
// -----------------------------------------------------------------------------
module regfile_param
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = DEF_NUM_RD,
  parameter int PC_IDX = DEF_PC_IDX
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_valid,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     pc_rd_en,
  output logic [DATA_W-1:0]        pc_rd_data,
  input  logic                     pc_wr_en,
  input  logic [DATA_W-1:0]        pc_wr_data
);

  localparam int              DEPTH   = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(PC_IDX);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic              dwr_en_s;
  logic              pc_valid_unused_s;

  // A data write aimed at the PC entry is dropped when the PC is also written.
  always_comb begin
    if (pc_wr_en && (wr_addr == PC_ADDR)) begin
      dwr_en_s = 1'b0;
    end else begin
      dwr_en_s = wr_en;
    end
  end

  // Storage array: cleared on reset, otherwise takes the arbitrated writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem_r[k] <= DATA_W'(RESET_VAL);
      end
    end else begin
      if (dwr_en_s) begin
        mem_r[wr_addr] <= wr_data;
      end
      if (pc_wr_en) begin
        mem_r[PC_ADDR] <= pc_wr_data;
      end
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    regfile_rd_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_port (
      .clk     (clk),
      .rst     (rst),
      .en      (rd_en[g]),
      .addr    (rd_addr[g*ADDR_W +: ADDR_W]),
      .entries (mem_r),
      .wa_en   (dwr_en_s),
      .wa_addr (wr_addr),
      .wa_data (wr_data),
      .wb_en   (pc_wr_en),
      .wb_addr (PC_ADDR),
      .wb_data (pc_wr_data),
      .data    (rd_data[g*DATA_W +: DATA_W]),
      .valid   (rd_valid[g])
    );
  end

  // Fetch-stage PC port: same read port with its address tied to the PC entry.
  regfile_rd_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_pc_port (
    .clk     (clk),
    .rst     (rst),
    .en      (pc_rd_en),
    .addr    (PC_ADDR),
    .entries (mem_r),
    .wa_en   (dwr_en_s),
    .wa_addr (wr_addr),
    .wa_data (wr_data),
    .wb_en   (pc_wr_en),
    .wb_addr (PC_ADDR),
    .wb_data (pc_wr_data),
    .data    (pc_rd_data),
    .valid   (pc_valid_unused_s)
  );

endmodule

// File: tb/tb_regfile_param.sv
// -----------------------------------------------------------------------------
// tb_regfile_param
// Directed plus randomised bench for regfile_param (default geometry:
// 32-bit data, 16 entries, 3 read ports, PC at entry 15). Expected values
// come from a reference model kept as a plain array; directed steps also
// compare against literal constants.
// -----------------------------------------------------------------------------
module tb_regfile_param;

  logic        clk;
  logic        rst;
  logic [2:0]  rd_en;
  logic [11:0] rd_addr;
  logic [95:0] rd_data;
  logic [2:0]  rd_valid;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic        pc_rd_en;
  logic [31:0] pc_rd_data;
  logic        pc_wr_en;
  logic [31:0] pc_wr_data;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // reference model state
  logic [31:0] mem_m [16];
  logic [31:0] exp_rd [3];
  logic [2:0]  exp_valid;
  logic [31:0] exp_pc;

  regfile_param #(
    .DATA_W (32),
    .ADDR_W (4),
    .NUM_RD (3),
    .PC_IDX (15)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .pc_rd_en   (pc_rd_en),
    .pc_rd_data (pc_rd_data),
    .pc_wr_en   (pc_wr_en),
    .pc_wr_data (pc_wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // What a read of entry a returns this cycle, given the inputs being presented.
  function automatic logic [31:0] model_read(input int a);
    logic [31:0] v;
    v = mem_m[a];
`ifdef REGFILE_BYPASS_EN
    if (pc_wr_en && a == 15) v = pc_wr_data;
    else if (wr_en && int'(wr_addr) == a) v = wr_data;
`endif
    return v;
  endfunction

  // Apply one clock edge worth of behaviour to the model.
  task automatic model_edge();
    if (rst) begin
      for (int k = 0; k < 16; k++) mem_m[k] = 32'h0;
      for (int i = 0; i < 3; i++) exp_rd[i] = 32'h0;
      exp_valid = 3'b000;
      exp_pc    = 32'h0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (rd_en[i]) begin
          exp_rd[i]    = model_read(int'(rd_addr[i*4 +: 4]));
          exp_valid[i] = 1'b1;
        end else begin
          exp_valid[i] = 1'b0;
        end
      end
      if (pc_rd_en) exp_pc = model_read(15);
      // PC write applied last so it wins a collision on entry 15
      if (wr_en)    mem_m[wr_addr] = wr_data;
      if (pc_wr_en) mem_m[15] = pc_wr_data;
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rd_data[%0d]", i), rd_data[i*32 +: 32], exp_rd[i]);
    end
    chk("rd_valid", {29'h0, rd_valid}, {29'h0, exp_valid});
    chk("pc_rd_data", pc_rd_data, exp_pc);
  endtask

  // One clock: edge, model update, sample 1 time unit later, compare.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle();
    rst = 1'b0; rd_en = 3'b000; rd_addr = 12'h000;
    wr_en = 1'b0; wr_addr = 4'h0; wr_data = 32'h0;
    pc_rd_en = 1'b0; pc_wr_en = 1'b0; pc_wr_data = 32'h0;
  endtask

  initial begin
    logic [31:0] same_cycle_exp;
    idle();
    for (int k = 0; k < 16; k++) mem_m[k] = 32'h0;

    // reset
    rst = 1'b1;
    cycle();
    cycle();
    chk("reset_valid", {29'h0, rd_valid}, 32'h0);
    chk("reset_pc", pc_rd_data, 32'h0);

    // read r1, r2, r3 after reset
    idle();
    rd_en = 3'b111; rd_addr = {4'd3, 4'd2, 4'd1};
    cycle();
    chk("post_reset_valid", {29'h0, rd_valid}, 32'h7);
    chk("post_reset_rd2", rd_data[64 +: 32], 32'h0);

    // write r5, read it next cycle on port 1, then idle
    idle();
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'h2736AD89;
    cycle();
    idle();
    rd_en = 3'b010; rd_addr = {4'd0, 4'd5, 4'd0};
    cycle();
    chk("r5_read", rd_data[32 +: 32], 32'h2736AD89);
    idle();
    cycle();
    chk("r5_hold", rd_data[32 +: 32], 32'h2736AD89);
    chk("r5_valid_low", {31'h0, rd_valid[1]}, 32'h0);

    // same-cycle write and read of r7
    idle();
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 32'h173256AB;
    rd_en = 3'b001; rd_addr = {4'd0, 4'd0, 4'd7};
    cycle();
`ifdef REGFILE_BYPASS_EN
    same_cycle_exp = 32'h173256AB;
`else
    same_cycle_exp = 32'h0;
`endif
    chk("r7_same_cycle", rd_data[0 +: 32], same_cycle_exp);
    idle();
    rd_en = 3'b001; rd_addr = {4'd0, 4'd0, 4'd7};
    cycle();
    chk("r7_next_cycle", rd_data[0 +: 32], 32'h173256AB);

    // colliding writes to the PC entry
    idle();
    wr_en = 1'b1; wr_addr = 4'd15; wr_data = 32'h11;
    pc_wr_en = 1'b1; pc_wr_data = 32'h100;
    cycle();
    idle();
    pc_rd_en = 1'b1; rd_en = 3'b100; rd_addr = {4'd15, 4'd0, 4'd0};
    cycle();
    chk("pc_collision_pc", pc_rd_data, 32'h100);
    chk("pc_collision_r15", rd_data[64 +: 32], 32'h100);

    // all ports read r8
    idle();
    wr_en = 1'b1; wr_addr = 4'd8; wr_data = 32'hABCDEF12;
    cycle();
    idle();
    rd_en = 3'b111; rd_addr = {4'd8, 4'd8, 4'd8};
    cycle();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("r8_port%0d", i), rd_data[i*32 +: 32], 32'hABCDEF12);
    end

    // reset dominates a write and a read
    idle();
    wr_en = 1'b1; wr_addr = 4'd9; wr_data = 32'hBDAC1908;
    cycle();
    rst = 1'b1; wr_en = 1'b1; wr_addr = 4'd9; wr_data = 32'h1;
    rd_en = 3'b111; rd_addr = {4'd9, 4'd9, 4'd9}; pc_rd_en = 1'b1;
    cycle();
    chk("rst_dom_valid", {29'h0, rd_valid}, 32'h0);
    chk("rst_dom_rd0", rd_data[0 +: 32], 32'h0);
    chk("rst_dom_pc", pc_rd_data, 32'h0);
    idle();
    rd_en = 3'b001; rd_addr = {4'd0, 4'd0, 4'd9};
    cycle();
    chk("r9_after_rst", rd_data[0 +: 32], 32'h0);

    // randomised traffic, biased toward the PC entry to exercise collisions
    for (int n = 0; n < 400; n++) begin
      rst        = ($urandom_range(0, 40) == 0);
      rd_en      = 3'($urandom);
      for (int i = 0; i < 3; i++) begin
        rd_addr[i*4 +: 4] = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
      end
      wr_en      = 1'($urandom);
      wr_addr    = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
      wr_data    = $urandom;
      pc_rd_en   = 1'($urandom);
      pc_wr_en   = ($urandom_range(0, 2) == 0);
      pc_wr_data = $urandom;
      cycle();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
